// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests over
// a ready handshake, and holds the IF/ID pipeline register. It redirects fetch
// from the ID-stage next-PC selection with one architectural delay slot. A
// one-entry skid buffer catches a fetch that returns while ID is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic [1:0]  id_npc_sel,
  input  logic        id_npc_op,
  input  logic        id_br_eq,
  input  logic [31:0] id_jr_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] SEL_ADD4   = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  logic [0:0]  state;
  logic [31:0] pc;
  logic        skValid;
  logic [31:0] skInstr;
  logic [31:0] skPc4;
  logic        rdValid;
  logic [31:0] rdTarget;

  logic        adv;
  logic        complete;
  logic        redir;
  logic [31:0] fetchPc4;
  logic [31:0] branchOffset;
  logic [31:0] redirTarget;

  // A full skid buffer blocks new requests, so at most one fetched
  // instruction ever sits beyond IF/ID.
  assign imem_req  = (state == RUN) && !skValid;
  assign imem_addr = pc;
  assign adv       = !if_id_valid || !id_stall;
  assign complete  = imem_req && imem_ready;
  assign fetchPc4  = pc + 32'd4;

  // Decide whether the instruction leaving IF/ID redirects fetch.
  always_comb begin
    redir = 1'b0;
    if (if_id_valid && !id_stall) begin
      case (id_npc_sel)
        SEL_JUMP:   redir = id_npc_op;
        SEL_BRANCH: redir = id_br_eq;
        SEL_JR:     redir = 1'b1;
        SEL_ADD4:   redir = 1'b0;
        default:    redir = 1'b0;
      endcase
    end
  end

  // Compute the redirect target from the instruction held in IF/ID.
  always_comb begin
    branchOffset = {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
    case (id_npc_sel)
      SEL_JUMP:   redirTarget = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
      SEL_BRANCH: redirTarget = if_id_pc4 + branchOffset;
      default:    redirTarget = id_jr_target & 32'hFFFF_FFFC;
    endcase
  end

  // PC, boot sequencing and the deferred redirect.
  // A redirect seen while the delay-slot fetch is still waiting on memory is
  // parked in rdTarget and applied when that fetch completes, so the delay
  // slot is never dropped and no flush is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      rdValid  <= 1'b0;
      rdTarget <= '0;
    end else begin
      if (state == BOOT) begin
        state <= RUN;
      end
      if (complete) begin
        if (redir) begin
          pc <= redirTarget;
        end else if (rdValid) begin
          pc      <= rdTarget;
          rdValid <= 1'b0;
        end else begin
          pc <= fetchPc4;
        end
      end else if (redir) begin
        if (!imem_req) begin
          pc <= redirTarget;
        end else begin
          rdTarget <= redirTarget;
          rdValid  <= 1'b1;
        end
      end
    end
  end

  // IF/ID register and skid buffer; the skid drains ahead of any new fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      skValid     <= 1'b0;
      skInstr     <= '0;
      skPc4       <= '0;
    end else begin
      if (adv) begin
        if (skValid) begin
          if_id_valid <= 1'b1;
          if_id_instr <= skInstr;
          if_id_pc4   <= skPc4;
          skValid     <= 1'b0;
        end else if (complete) begin
          if_id_valid <= 1'b1;
          if_id_instr <= imem_rdata;
          if_id_pc4   <= fetchPc4;
        end else begin
          if_id_valid <= 1'b0;
        end
      end else if (complete) begin
        skValid <= 1'b1;
        skInstr <= imem_rdata;
        skPc4   <= fetchPc4;
      end
    end
  end

endmodule
